// File: rtl/clk_divider_bank_pkg.sv
// Shared constants and types for the clock divider bank.
// Frequency divisors assume a 12 MHz system clock on clk_in.
package clk_divider_bank_pkg;

    localparam int unsigned SYS_CLK_HZ = 12_000_000;

    // Divisors producing common output rates from SYS_CLK_HZ
    localparam int unsigned F_1HZ      = SYS_CLK_HZ;
    localparam int unsigned F_2HZ      = SYS_CLK_HZ / 2;
    localparam int unsigned F_10HZ     = SYS_CLK_HZ / 10;
    localparam int unsigned F_100HZ    = SYS_CLK_HZ / 100;
    localparam int unsigned F_1KHZ     = SYS_CLK_HZ / 1_000;
    localparam int unsigned F_9600BD   = SYS_CLK_HZ / 9_600;
    localparam int unsigned F_115200BD = SYS_CLK_HZ / 115_200;

    localparam int unsigned DIV_MIN    = 2;

    // Outcome of decoding one configuration write strobe
    typedef enum logic [1:0] {
        CFG_IDLE    = 2'd0,
        CFG_OK      = 2'd1,
        CFG_BAD_DIV = 2'd2,
        CFG_BAD_CH  = 2'd3
    } cfg_res_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor,
// registered tick strobe and square-wave output.
module clk_div_chan
    import clk_divider_bank_pkg::*;
#(
    parameter int          W           = 24,
    parameter int unsigned DEFAULT_DIV = F_1HZ
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wr_div,
    output logic         pend,
    output logic         tick,
    output logic         clk_out
);

    localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

    logic [W-1:0] cnt;
    logic [W-1:0] div_act;
    logic [W-1:0] div_pend;

    logic [W-1:0] cnt_nx;
    logic [W-1:0] div_nx;
    logic         clk_nx;
    logic         last;
    logic         apply;

    // Next counter/divisor: pending divisors only land on a period
    // boundary, or straight away while the channel is stopped
    always_comb begin
        last   = (cnt == div_act - W'(1));
        cnt_nx = cnt;
        div_nx = div_act;
        clk_nx = clk_out;
        apply  = 1'b0;
        if (en) begin
            if (last) begin
                cnt_nx = '0;
                if (pend) begin
                    div_nx = div_pend;
                    apply  = 1'b1;
                end
            end else begin
                cnt_nx = cnt + W'(1);
            end
            clk_nx = (cnt_nx >= (div_nx >> 1));
        end else if (pend) begin
            cnt_nx = '0;
            div_nx = div_pend;
            clk_nx = 1'b0;
            apply  = 1'b1;
        end
    end

    // Counter, divisor and output registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            div_act <= DIV_RST;
            tick    <= 1'b0;
            clk_out <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            div_act <= div_nx;
            tick    <= en && last;
            clk_out <= clk_nx;
        end
    end

    // Pending divisor: a new write wins over a same-edge apply
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_pend <= DIV_RST;
            pend     <= 1'b0;
        end else if (wr) begin
            div_pend <= wr_div;
            pend     <= 1'b1;
        end else if (apply) begin
            pend     <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of NCH run-time programmable clock dividers sharing one
// configuration write port.
module clk_divider_bank
    import clk_divider_bank_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          W           = 24,
    parameter int unsigned DEFAULT_DIV = F_1HZ
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          en,
    input  logic                    cfg_we,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [W-1:0]            cfg_div,
    output logic                    cfg_err,
    output logic [NCH-1:0]          pend,
    output logic [NCH-1:0]          tick,
    output logic [NCH-1:0]          clk_out
);

    localparam int CW = $clog2(NCH);

    if (NCH < 2) begin : g_bad_nch
        $error("clk_divider_bank: NCH must be at least 2");
    end
    if (DEFAULT_DIV < DIV_MIN ||
        64'(DEFAULT_DIV) >= (64'd1 << W)) begin : g_bad_div
        $error("clk_divider_bank: DEFAULT_DIV out of range");
    end

    cfg_res_e       res;
    logic           div_ok;
    logic           ch_ok;
    logic [NCH-1:0] wr;

    assign div_ok = (cfg_div >= W'(DIV_MIN));
    assign ch_ok  = (32'(cfg_ch) < 32'(NCH));

    // Classify the write strobe; items are mutually exclusive
    always_comb begin
        res = CFG_IDLE;
        unique case (1'b1)
            !cfg_we:                   res = CFG_IDLE;
            cfg_we && !div_ok:         res = CFG_BAD_DIV;
            cfg_we && div_ok && !ch_ok: res = CFG_BAD_CH;
            cfg_we && div_ok && ch_ok:  res = CFG_OK;
            default:                   res = CFG_IDLE;
        endcase
    end

    // One-hot write enable towards the addressed channel
    always_comb begin
        wr = '0;
        for (int i = 0; i < NCH; i++) begin
            wr[i] = (res == CFG_OK) && (32'(cfg_ch) == 32'(i));
        end
    end

    // Rejected-write flag, one cycle per bad strobe
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= (res == CFG_BAD_DIV) || (res == CFG_BAD_CH);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_div_chan #(
            .W           (W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .en      (en[g]),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .pend    (pend[g]),
            .tick    (tick[g]),
            .clk_out (clk_out[g])
        );
    end

    logic [CW-1:0] unused_ch;
    assign unused_ch = cfg_ch;

endmodule

// File: tb/tb_clk_divider_bank.sv
// Scoreboard bench for clk_divider_bank against a per-channel
// period/phase reference model.
module tb_clk_divider_bank;

    localparam int NCH  = 3;
    localparam int W    = 8;
    localparam int DDIV = 4;
    localparam int CW   = $clog2(NCH);

    logic           clk_in = 1'b0;
    logic           rst_n  = 1'b0;
    logic [NCH-1:0] en     = '0;
    logic           cfg_we = 1'b0;
    logic [CW-1:0]  cfg_ch = '0;
    logic [W-1:0]   cfg_div = '0;
    logic           cfg_err;
    logic [NCH-1:0] pend;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] clk_out;

    clk_divider_bank #(
        .NCH         (NCH),
        .W           (W),
        .DEFAULT_DIV (DDIV)
    ) dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_err (cfg_err),
        .pend    (pend),
        .tick    (tick),
        .clk_out (clk_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] co;
        logic [NCH-1:0] pend;
        logic           err;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int popped = 0;

    // Reference model: position within period, period length,
    // pending divisor, and current square-wave level
    int m_pos[NCH];
    int m_per[NCH];
    int m_pd[NCH];
    bit m_pv[NCH];
    bit m_co[NCH];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_pos[i] = 0;
            m_per[i] = DDIV;
            m_pd[i]  = 0;
            m_pv[i]  = 1'b0;
            m_co[i]  = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus and queue the expected response
    task automatic cyc(input logic [NCH-1:0] e, input logic we,
                       input int ch, input int dv);
        exp_t x;
        bit ok;
        @(negedge clk_in);
        en      = e;
        cfg_we  = we;
        cfg_ch  = CW'(ch);
        cfg_div = W'(dv);
        ok = we && dv >= 2 && ch < NCH;
        x = '0;
        x.err = we && !ok;
        for (int i = 0; i < NCH; i++) begin
            if (e[i]) begin
                if (m_pos[i] == m_per[i] - 1) begin
                    m_pos[i] = 0;
                    if (m_pv[i]) begin
                        m_per[i] = m_pd[i];
                        m_pv[i]  = 1'b0;
                    end
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
                x.tick[i] = (m_pos[i] == 0);
                m_co[i]   = (m_pos[i] >= m_per[i] / 2);
            end else if (m_pv[i]) begin
                m_per[i] = m_pd[i];
                m_pv[i]  = 1'b0;
                m_pos[i] = 0;
                m_co[i]  = 1'b0;
            end
            if (ok && ch == i) begin
                m_pd[i] = dv;
                m_pv[i] = 1'b1;
            end
            x.co[i]   = m_co[i];
            x.pend[i] = m_pv[i];
        end
        sbq.push_back(x);
        pushed++;
    endtask

    task automatic run(input logic [NCH-1:0] e, input int n);
        for (int k = 0; k < n; k++) cyc(e, 1'b0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
        chk({tag, "_clk_out"}, 32'(clk_out), 32'd0);
        chk({tag, "_pend"}, 32'(pend), 32'd0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    endtask

    // Monitor: compare DUT outputs just after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            #1;
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                popped++;
                chk("tick", 32'(tick), 32'(e.tick));
                chk("clk_out", 32'(clk_out), 32'(e.co));
                chk("pend", 32'(pend), 32'(e.pend));
                chk("cfg_err", 32'(cfg_err), 32'(e.err));
            end
        end
    end

    initial begin
        int n;
        logic [NCH-1:0] re;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        run('1, 12);

        cyc('1, 1'b1, 1, 5);
        run('1, 16);

        cyc('1, 1'b1, 0, 1);
        cyc('1, 1'b0, 0, 0);
        cyc('1, 1'b1, 3, 6);
        run('1, 4);

        cyc(3'b110, 1'b0, 0, 0);
        cyc(3'b110, 1'b1, 0, 6);
        run(3'b110, 3);
        run('1, 16);

        cyc('1, 1'b1, 2, 7);
        cyc('1, 1'b1, 2, 9);
        run('1, 24);

        cyc('1, 1'b1, 2, 3);
        n = 0;
        while (m_pos[2] != m_per[2] - 1 && n < 40) begin
            cyc('1, 1'b0, 0, 0);
            n++;
        end
        chk("wrap_wait_bound", 32'(n < 40), 32'd1);
        cyc('1, 1'b1, 2, 8);
        run('1, 20);

        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++) re[i] = ($urandom % 8) != 0;
            cyc(re, ($urandom % 3) == 0, int'($urandom % 4),
                int'($urandom % 13));
        end

        run('1, 3);
        cyc('1, 1'b1, 1, 10);
        cyc('1, 1'b0, 0, 0);
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n = 1'b1;
        run('1, 12);

        repeat (2) @(posedge clk_in);
        #2;
        chk("sb_drain", 32'(popped), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
